// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: state encoding, register
// offsets, source indices and a one-hot helper.
package irq_ctrl_pkg;

  localparam int unsigned SRC_W  = 6;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_EDGE    = 2'd2;
  localparam logic [1:0] IRQ_STATUS  = 2'd3;

  localparam int unsigned IRQ_SRC_TC0 = 0;
  localparam int unsigned IRQ_SRC_TC1 = 1;
  localparam int unsigned IRQ_SRC_EXT = 2;

  // Ids 6 and 7 shift out of the 6-bit result and map to zero.
  function automatic logic [SRC_W-1:0] irq_onehot(input logic [ID_W-1:0] id);
    logic [SRC_W:0] wide;
    wide = (SRC_W+1)'(1) << id;
    return SRC_W'(wide);
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; returns the lowest set index.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [SRC_W-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = SRC_W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level capture, masking, fixed priority
// and a request/ack/eret handshake with the CPU, plus a 4-word register window.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned      N_SRC    = 6,
  parameter logic [SRC_W-1:0] RST_MASK = 6'h3F,
  parameter logic [SRC_W-1:0] RST_EDGE = 6'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SRC_W-1:0]  src_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [SRC_W-1:0]  int_req,
  input  logic              cpu_ack,
  input  logic              cpu_eret,
  output logic [ID_W-1:0]   irq_id
);

  // Bits at N_SRC and above are tied off everywhere.
  localparam logic [SRC_W-1:0] SRC_EN = SRC_W'(((SRC_W+1)'(1) << N_SRC) - (SRC_W+1)'(1));

  irq_state_e       state_q;
  logic [ID_W-1:0]  irq_id_q;
  logic [SRC_W-1:0] int_req_q;
  logic [SRC_W-1:0] src_q;
  logic [SRC_W-1:0] edge_q, edge_d;
  logic [SRC_W-1:0] mask_q, mask_d;
  logic [SRC_W-1:0] edge_cfg_q, edge_cfg_d;

  logic [SRC_W-1:0] pending;
  logic [SRC_W-1:0] eff;
  logic [SRC_W-1:0] rise;
  logic [SRC_W-1:0] w1c;
  logic [SRC_W-1:0] ack_clr;
  logic             wr_pend, wr_mask, wr_edge;
  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic             granted_live;
  logic             unused_bits;

  assign unused_bits = ^{addr[ADDR_W-1:2], wdata[DATA_W-1:SRC_W]};

  assign wr_pend = we && (addr[1:0] == IRQ_PENDING);
  assign wr_mask = we && (addr[1:0] == IRQ_MASK);
  assign wr_edge = we && (addr[1:0] == IRQ_EDGE);

  // Pending view: latched bit for edge sources, sampled input for level ones.
  always_comb begin
    pending      = ((edge_q & edge_cfg_q) | (src_q & ~edge_cfg_q)) & SRC_EN;
    eff          = pending & mask_q;
    granted_live = |(eff & irq_onehot(irq_id_q));
  end

  // Edge latch update: rising edge beats any clear in the same cycle; a
  // source leaving edge mode drops its latch.
  always_comb begin
    mask_d     = wr_mask ? (wdata[SRC_W-1:0] & SRC_EN) : mask_q;
    edge_cfg_d = wr_edge ? (wdata[SRC_W-1:0] & SRC_EN) : edge_cfg_q;
    rise       = src_req & ~src_q & SRC_EN;
    w1c        = wr_pend ? wdata[SRC_W-1:0] : '0;
    ack_clr    = ((state_q == IRQ_REQ) && cpu_ack) ? irq_onehot(irq_id_q) : '0;
    edge_d     = (rise | (edge_q & ~(w1c | ack_clr))) & edge_cfg_q & edge_cfg_d;
  end

  irq_prio_enc u_prio (
    .req_i   (eff),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      edge_q     <= '0;
      mask_q     <= RST_MASK & SRC_EN;
      edge_cfg_q <= RST_EDGE & SRC_EN;
    end else begin
      src_q      <= src_req & SRC_EN;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      edge_cfg_q <= edge_cfg_d;
    end
  end

  // Handshake FSM; int_req is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IRQ_IDLE;
      irq_id_q  <= '0;
      int_req_q <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          int_req_q <= '0;
          if (win_valid) begin
            state_q   <= IRQ_REQ;
            irq_id_q  <= win_id;
            int_req_q <= irq_onehot(win_id);
          end
        end
        IRQ_REQ: begin
          if (cpu_ack) begin
            state_q   <= IRQ_SVC;
            int_req_q <= '0;
          end else if (!granted_live) begin
            state_q   <= IRQ_IDLE;
            int_req_q <= '0;
          end
        end
        IRQ_SVC: begin
          int_req_q <= '0;
          if (cpu_eret) begin
            state_q <= IRQ_IDLE;
          end
        end
        default: begin
          state_q   <= IRQ_IDLE;
          int_req_q <= '0;
        end
      endcase
    end
  end

  // Register read mux, combinational from addr.
  always_comb begin
    rdata = '0;
    case (addr[1:0])
      IRQ_PENDING: rdata[SRC_W-1:0] = pending;
      IRQ_MASK:    rdata[SRC_W-1:0] = mask_q;
      IRQ_EDGE:    rdata[SRC_W-1:0] = edge_cfg_q;
      IRQ_STATUS: begin
        rdata[1:0]  = 2'(state_q);
        rdata[4:2]  = irq_id_q;
        rdata[10:5] = edge_q;
      end
      default: rdata = '0;
    endcase
  end

  assign int_req = int_req_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared against a per-cycle behavioural model of the controller.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_req;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  int_req;
  logic        cpu_ack;
  logic        cpu_eret;
  logic [2:0]  irq_id;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .src_req  (src_req),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .int_req  (int_req),
    .cpu_ack  (cpu_ack),
    .cpu_eret (cpu_eret),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 requesting, 2 in service.
  logic [5:0] m_src_q, m_latch, m_mask, m_edge;
  int         m_state;
  int         m_id;

  function automatic logic [5:0] m_pend();
    logic [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = m_edge[i] ? m_latch[i] : m_src_q[i];
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[5:0] = m_pend();
      2'd1: r[5:0] = m_mask;
      2'd2: r[5:0] = m_edge;
      default: begin
        r[1:0]  = 2'(m_state);
        r[4:2]  = 3'(m_id);
        r[10:5] = m_latch;
      end
    endcase
    return r;
  endfunction

  function automatic logic [5:0] m_int_req();
    logic [5:0] v;
    v = '0;
    if (m_state == 1) v[m_id] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic [5:0] eff, nmask, nedge, nlatch;
    int ns, nid;
    bit rise, clr;
    if (reset) begin
      m_src_q = '0; m_latch = '0; m_mask = 6'h3F; m_edge = '0;
      m_state = 0;  m_id = 0;
    end else begin
      eff = m_pend() & m_mask;
      ns  = m_state;
      nid = m_id;
      if (m_state == 0) begin
        if (eff != 0) begin
          for (int i = 5; i >= 0; i--) if (eff[i]) nid = i;
          ns = 1;
        end
      end else if (m_state == 1) begin
        if (cpu_ack) ns = 2;
        else if (!eff[m_id]) ns = 0;
      end else begin
        if (cpu_eret) ns = 0;
      end
      nmask = m_mask;
      nedge = m_edge;
      if (we && addr[1:0] == 2'd1) nmask = wdata[5:0];
      if (we && addr[1:0] == 2'd2) nedge = wdata[5:0];
      for (int i = 0; i < 6; i++) begin
        rise = src_req[i] && !m_src_q[i];
        clr  = (we && addr[1:0] == 2'd0 && wdata[i]) || (m_state == 1 && cpu_ack && m_id == i);
        nlatch[i] = rise ? 1'b1 : (clr ? 1'b0 : m_latch[i]);
        if (!m_edge[i] || !nedge[i]) nlatch[i] = 1'b0;
      end
      m_latch = nlatch; m_mask = nmask; m_edge = nedge;
      m_src_q = src_req; m_state = ns; m_id = nid;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a}; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    cpu_eret = 1'b1; tick(); cpu_eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++; if (int_req !== 6'h00) begin n_err++; $display("FAIL reset_int_req: got %h exp 00", int_req); end
    n_vec++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_irq_id: got %0d exp 0", irq_id); end
    addr = 30'd1; #1;
    n_vec++; if (rdata !== 32'h3F) begin n_err++; $display("FAIL reset_mask: got %h exp 3f", rdata); end
    addr = 30'd3; #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h exp 0", rdata); end
  endtask

  task automatic test_level();
    src_req = 6'b000100;
    tick();
    n_vec++; if (int_req !== 6'h00) begin n_err++; $display("FAIL level_early: got %h exp 00", int_req); end
    tick();
    n_vec++; if (int_req !== 6'b000100) begin n_err++; $display("FAIL level_req: got %h exp 04", int_req); end
    n_vec++; if (irq_id !== 3'd2) begin n_err++; $display("FAIL level_id: got %0d exp 2", irq_id); end
    pulse_ack();
    addr = 30'd3; #1;
    n_vec++; if (int_req !== 6'h00) begin n_err++; $display("FAIL level_svc_int: got %h exp 00", int_req); end
    n_vec++; if (rdata !== 32'h0A) begin n_err++; $display("FAIL level_svc_status: got %h exp 0a", rdata); end
    pulse_eret();
    n_vec++; if (int_req !== 6'h00) begin n_err++; $display("FAIL level_idle: got %h exp 00", int_req); end
    tick();
    n_vec++; if (int_req !== 6'b000100) begin n_err++; $display("FAIL level_rearm: got %h exp 04", int_req); end
    src_req = '0;
    tick(); tick();
    n_vec++; if (int_req !== 6'h00) begin n_err++; $display("FAIL level_drop: got %h exp 00", int_req); end
  endtask

  task automatic test_edge();
    wr(2'd2, 32'h03);
    src_req = 6'b000010; tick(); src_req = '0;
    tick();
    addr = 30'd0; #1;
    n_vec++; if (rdata !== 32'h02) begin n_err++; $display("FAIL edge_latched: got %h exp 02", rdata); end
    n_vec++; if (int_req !== 6'b000010 || irq_id !== 3'd1) begin n_err++; $display("FAIL edge_req: got %h/%0d exp 02/1", int_req, irq_id); end
    pulse_ack();
    addr = 30'd0; #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL edge_ack_clear: got %h exp 0", rdata); end
    pulse_eret();
  endtask

  task automatic test_priority();
    wr(2'd2, 32'h00);
    src_req = 6'b000110;
    tick(); tick();
    n_vec++; if (int_req !== 6'b000010 || irq_id !== 3'd1) begin n_err++; $display("FAIL prio_first: got %h/%0d exp 02/1", int_req, irq_id); end
    pulse_ack();
    src_req = 6'b000100;
    pulse_eret();
    tick();
    n_vec++; if (int_req !== 6'b000100 || irq_id !== 3'd2) begin n_err++; $display("FAIL prio_second: got %h/%0d exp 04/2", int_req, irq_id); end
    pulse_ack();
    src_req = '0;
    pulse_eret();
    tick();
  endtask

  task automatic test_mask();
    src_req = 6'b000101;
    tick(); tick();
    n_vec++; if (int_req !== 6'b000001 || irq_id !== 3'd0) begin n_err++; $display("FAIL mask_pre: got %h/%0d exp 01/0", int_req, irq_id); end
    wr(2'd1, 32'h3E);
    tick();
    addr = 30'd3; #1;
    n_vec++; if (int_req !== 6'h00 || rdata[1:0] !== 2'd0) begin n_err++; $display("FAIL mask_drop: got %h/st%0d exp 00/st0", int_req, rdata[1:0]); end
    tick();
    n_vec++; if (int_req !== 6'b000100 || irq_id !== 3'd2) begin n_err++; $display("FAIL mask_next: got %h/%0d exp 04/2", int_req, irq_id); end
    src_req = '0;
    wr(2'd1, 32'h3F);
    tick(); tick();
  endtask

  task automatic test_w1c_race();
    wr(2'd2, 32'h01);
    tick();
    src_req = 6'b000001; addr = 30'd0; wdata = 32'h01; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0; addr = 30'd0; #1;
    n_vec++; if (rdata !== 32'h01) begin n_err++; $display("FAIL w1c_set_wins: got %h exp 01", rdata); end
    tick();
    pulse_ack();
    src_req = '0;
    pulse_eret();
    tick();
  endtask

  task automatic test_reset_service();
    src_req = 6'b000001; tick(); src_req = '0;
    tick();
    pulse_ack();
    addr = 30'd3; #1;
    n_vec++; if (rdata[1:0] !== 2'd2) begin n_err++; $display("FAIL rst_pre_svc: got st%0d exp st2", rdata[1:0]); end
    reset = 1'b1; tick(); reset = 1'b0;
    addr = 30'd3; #1;
    n_vec++; if (int_req !== 6'h00 || rdata !== 32'h0) begin n_err++; $display("FAIL rst_svc_state: got %h/%h exp 00/0", int_req, rdata); end
    addr = 30'd1; #1;
    n_vec++; if (rdata !== 32'h3F) begin n_err++; $display("FAIL rst_svc_mask: got %h exp 3f", rdata); end
    addr = 30'd2; #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_svc_edge: got %h exp 0", rdata); end
    wr(2'd2, 32'h01);
    src_req = 6'b000001; tick(); src_req = '0;
    tick();
    n_vec++; if (int_req !== 6'b000001 || irq_id !== 3'd0) begin n_err++; $display("FAIL rst_then_edge: got %h/%0d exp 01/0", int_req, irq_id); end
    pulse_ack();
    pulse_eret();
  endtask

  task automatic test_random();
    logic [31:0] exp_r;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(7) == 0) src_req[b] = ~src_req[b];
      cpu_ack  = ($urandom_range(3) == 0);
      cpu_eret = ($urandom_range(3) == 0);
      we       = ($urandom_range(9) == 0);
      addr     = 30'($urandom);
      wdata    = $urandom;
      reset    = ($urandom_range(299) == 0);
      tick();
      reset = 1'b0; we = 1'b0; cpu_ack = 1'b0; cpu_eret = 1'b0;
      addr = 30'($urandom); #1;
      exp_r = m_read(addr[1:0]);
      n_vec++; if (int_req !== m_int_req()) begin n_err++; $display("FAIL rnd_int_req @%0d: got %h exp %h", n, int_req, m_int_req()); end
      n_vec++; if (rdata !== exp_r) begin n_err++; $display("FAIL rnd_rdata @%0d a%0d: got %h exp %h", n, addr[1:0], rdata, exp_r); end
      if (m_state != 0) begin
        n_vec++; if (irq_id !== 3'(m_id)) begin n_err++; $display("FAIL rnd_irq_id @%0d: got %0d exp %0d", n, irq_id, m_id); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; src_req = '0; addr = '0; we = 1'b0; wdata = '0;
    cpu_ack = 1'b0; cpu_eret = 1'b0;
    m_src_q = '0; m_latch = '0; m_mask = 6'h3F; m_edge = '0; m_state = 0; m_id = 0;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_mask();
    test_w1c_race();
    test_reset_service();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
